// File: rtl/can_bit_destuff_if.sv
// rtl/can_bit_destuff_if.sv - sample-point and de-stuff status bundle around the CAN bit de-stuffer
// master: bit timing / protocol FSM side; slave: the de-stuffer.
interface can_bit_destuff_if #(
  parameter int CNT_W = 3
);
  logic             sample_point_i;
  logic             sampled_bit_i;
  logic             stuff_en_i;
  logic             fixed_start_i;
  logic             bit_de_stuff_o;
  logic             stuff_err_o;
  logic [CNT_W-1:0] stuff_cnt_o;
  logic [CNT_W-1:0] stuff_cnt_gray_o;
  logic             stuff_parity_o;

  modport master (
    output sample_point_i, sampled_bit_i, stuff_en_i, fixed_start_i,
    input  bit_de_stuff_o, stuff_err_o, stuff_cnt_o, stuff_cnt_gray_o, stuff_parity_o
  );

  modport slave (
    input  sample_point_i, sampled_bit_i, stuff_en_i, fixed_start_i,
    output bit_de_stuff_o, stuff_err_o, stuff_cnt_o, stuff_cnt_gray_o, stuff_parity_o
  );
endinterface

// File: rtl/can_bit_destuff.sv
// rtl/can_bit_destuff.sv - CAN bit de-stuffer: stuff-bit flag, stuff errors, modulo stuff count
// Defining CAN_DESTUFF_FIXED_EN adds the FD fixed-stuffing state used across the CRC field.
module can_bit_destuff #(
  parameter int RUN_LEN      = 5,
  parameter int FIXED_PERIOD = 4,
  parameter int CNT_W        = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  can_bit_destuff_if.slave bus
);
  localparam int RUN_W = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {
    DS_IDLE  = 2'd0,
`ifdef CAN_DESTUFF_FIXED_EN
    DS_FIXED = 2'd2,
`endif
    DS_DYN   = 2'd1
  } ds_state_e;

  ds_state_e        state, state_nxt;
  logic             prev_bit, prev_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt;
  logic             flag, flag_nxt;
  logic             err, err_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic sp, en, b;
  assign sp = bus.sample_point_i;
  assign en = bus.stuff_en_i;
  assign b  = bus.sampled_bit_i;

`ifdef CAN_DESTUFF_FIXED_EN
  localparam int FIX_W = $clog2(FIXED_PERIOD + 1);
  logic [FIX_W-1:0] fix_cnt, fix_nxt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fix_cnt <= '0;
    else       fix_cnt <= fix_nxt;
  end
`else
  logic unused_fixed_start;
  assign unused_fixed_start = bus.fixed_start_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= DS_IDLE;
      prev_bit <= 1'b0;
      run_cnt  <= '0;
      flag     <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      prev_bit <= prev_nxt;
      run_cnt  <= run_nxt;
      flag     <= flag_nxt;
      err      <= err_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Dropping stuff_en wins over any sample point arriving on the same edge.
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = DS_IDLE;
    end else if (sp) begin
      case (state)
        DS_IDLE: if (!b) state_nxt = DS_DYN;
        DS_DYN: begin
`ifdef CAN_DESTUFF_FIXED_EN
          if (bus.fixed_start_i) state_nxt = DS_FIXED;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prev_nxt = prev_bit;
    run_nxt  = run_cnt;
    flag_nxt = flag;
    err_nxt  = 1'b0;
    cnt_nxt  = cnt;
`ifdef CAN_DESTUFF_FIXED_EN
    fix_nxt  = fix_cnt;
`endif
    if (!en) begin
      flag_nxt = 1'b0;
      run_nxt  = '0;
`ifdef CAN_DESTUFF_FIXED_EN
      fix_nxt  = '0;
`endif
    end else if (sp) begin
      case (state)
        DS_IDLE: begin
          if (!b) begin
            prev_nxt = 1'b0;
            run_nxt  = RUN_W'(1);
            cnt_nxt  = '0;
          end
        end
        DS_DYN: begin
          if (flag) begin
            err_nxt  = (b == prev_bit);
            run_nxt  = RUN_W'(1);
            cnt_nxt  = cnt + CNT_W'(1);
            flag_nxt = 1'b0;
          end else begin
            if (b != prev_bit)                     run_nxt = RUN_W'(1);
            else if (run_cnt < RUN_W'(RUN_LEN))    run_nxt = run_cnt + RUN_W'(1);
            flag_nxt = (run_nxt == RUN_W'(RUN_LEN));
          end
          prev_nxt = b;
`ifdef CAN_DESTUFF_FIXED_EN
          // The fixed stuff bit absorbs any pending dynamic stuff request uncounted.
          if (bus.fixed_start_i) begin
            flag_nxt = 1'b1;
            fix_nxt  = '0;
          end
`endif
        end
`ifdef CAN_DESTUFF_FIXED_EN
        DS_FIXED: begin
          if (flag) begin
            err_nxt  = (b == prev_bit);
            fix_nxt  = '0;
            flag_nxt = 1'b0;
          end else begin
            fix_nxt  = fix_cnt + FIX_W'(1);
            flag_nxt = (fix_nxt == FIX_W'(FIXED_PERIOD));
          end
          prev_nxt = b;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.bit_de_stuff_o   = flag;
  assign bus.stuff_err_o      = err;
  assign bus.stuff_cnt_o      = cnt;
  assign bus.stuff_cnt_gray_o = cnt ^ (cnt >> 1);
  assign bus.stuff_parity_o   = ^bus.stuff_cnt_gray_o;
endmodule

// File: tb/tb_can_bit_destuff.sv
// tb/tb_can_bit_destuff.sv - randomized self-checking bench for can_bit_destuff
// Reference model works on bit histories and counts rather than the RTL's registers.
module tb_can_bit_destuff;
  localparam int RUN_LEN      = 5;
  localparam int FIXED_PERIOD = 4;
  localparam logic [2:0] GRAY [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  can_bit_destuff_if #(.CNT_W(3)) bus ();

  can_bit_destuff #(.RUN_LEN(RUN_LEN), .FIXED_PERIOD(FIXED_PERIOD), .CNT_W(3)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int m_state;
  bit m_prev, m_flag, m_err;
  bit m_hist[$];
  int m_fixn;
  int m_cnt;

  function automatic void model_reset();
    m_state = 0; m_prev = 0; m_flag = 0; m_err = 0; m_fixn = 0; m_cnt = 0;
    m_hist.delete();
  endfunction

  function automatic bit last_run_equal();
    if (m_hist.size() < RUN_LEN) return 1'b0;
    foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(bit sp, bit b, bit fs, bit en);
    m_err = 0;
    if (!en) begin
      m_state = 0; m_flag = 0; m_fixn = 0; m_hist.delete();
      return;
    end
    if (!sp) return;
    case (m_state)
      0: if (!b) begin
        m_state = 1; m_hist.delete(); m_hist.push_back(b); m_prev = b; m_cnt = 0;
      end
      1: begin
        if (m_flag) begin
          m_err = (b == m_prev); m_cnt++; m_flag = 0;
          m_hist.delete(); m_hist.push_back(b);
        end else begin
          m_hist.push_back(b);
          if (m_hist.size() > RUN_LEN) void'(m_hist.pop_front());
          m_flag = last_run_equal();
        end
        m_prev = b;
`ifdef CAN_DESTUFF_FIXED_EN
        if (fs) begin m_state = 2; m_flag = 1; m_fixn = 0; end
`endif
      end
      default: begin
        if (m_flag) begin
          m_err = (b == m_prev); m_fixn = 0; m_flag = 0;
        end else begin
          m_fixn++; m_flag = (m_fixn == FIXED_PERIOD);
        end
        m_prev = b;
      end
    endcase
  endfunction

  function automatic logic [6:0] exp_vec();
    logic [2:0] g;
    g = GRAY[m_cnt % 8];
    return {m_flag, m_err, 3'(m_cnt % 8), g, (($countones(g) % 2) == 1)};
  endfunction

  function automatic logic [6:0] obs_vec();
    return {bus.bit_de_stuff_o, bus.stuff_err_o, bus.stuff_cnt_o,
            bus.stuff_cnt_gray_o, bus.stuff_parity_o};
  endfunction

  task automatic tick(input bit sp, input bit b, input bit fs, input bit en);
    @(negedge clk);
    bus.sample_point_i = sp; bus.sampled_bit_i = b;
    bus.fixed_start_i  = fs; bus.stuff_en_i    = en;
    @(posedge clk);
    model_step(sp, b, fs, en);
    #1;
  endtask

  task automatic test_reset();
    bus.sample_point_i = 0; bus.sampled_bit_i = 1; bus.fixed_start_i = 0; bus.stuff_en_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_vec() !== 7'd0) begin bad++; $display("FAIL reset_outputs: got %b want %b", obs_vec(), 7'd0); end
    @(negedge clk); rst = 0;
    tick(1, 1, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL idle_recessive: got %b want %b", obs_vec(), exp_vec()); end
  endtask

  task automatic test_dynamic_stuff();
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 1);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL dyn_run bit%0d: got %b want %b", i, obs_vec(), exp_vec()); end
    end
    total++;
    if (bus.bit_de_stuff_o !== 1'b1) begin bad++; $display("FAIL dyn_flag_after_5: got %b want 1", bus.bit_de_stuff_o); end
    tick(1, 1, 0, 1);
    total++;
    if ({bus.bit_de_stuff_o, bus.stuff_err_o, bus.stuff_cnt_o} !== 5'b00_001) begin
      bad++; $display("FAIL dyn_stuff_ok: got %b want 00001", {bus.bit_de_stuff_o, bus.stuff_err_o, bus.stuff_cnt_o});
    end
  endtask

  task automatic test_stuff_error();
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1);
    repeat (5) tick(1, 1, 0, 1);
    total++;
    if (bus.bit_de_stuff_o !== 1'b1) begin bad++; $display("FAIL err_flag_set: got %b want 1", bus.bit_de_stuff_o); end
    tick(1, 1, 0, 1);
    total++;
    if (bus.stuff_err_o !== 1'b1) begin bad++; $display("FAIL err_pulse: got %b want 1", bus.stuff_err_o); end
    tick(0, 0, 0, 1);
    total++;
    if (bus.stuff_err_o !== 1'b0) begin bad++; $display("FAIL err_pulse_width: got %b want 0", bus.stuff_err_o); end
  endtask

  task automatic test_count_wrap();
    bit v;
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1);
    v = 0;
    for (int k = 0; k < 9; k++) begin
      repeat (4) tick(1, v, 0, 1);
      tick(1, ~v, 0, 1);
      v = ~v;
    end
    total++;
    if ({bus.stuff_cnt_o, bus.stuff_cnt_gray_o, bus.stuff_parity_o, bus.stuff_err_o} !== 8'b001_001_1_0) begin
      bad++; $display("FAIL count_wrap9: got %b want 00100110",
                      {bus.stuff_cnt_o, bus.stuff_cnt_gray_o, bus.stuff_parity_o, bus.stuff_err_o});
    end
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL count_wrap_model: got %b want %b", obs_vec(), exp_vec()); end
  endtask

`ifdef CAN_DESTUFF_FIXED_EN
  task automatic test_fixed();
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1); tick(1, 1, 0, 1); tick(1, 0, 0, 1);
    tick(1, 1, 1, 1);
    total++;
    if (bus.bit_de_stuff_o !== 1'b1) begin bad++; $display("FAIL fixed_first_flag: got %b want 1", bus.bit_de_stuff_o); end
    tick(1, 0, 0, 1);
    total++;
    if (bus.stuff_err_o !== 1'b0) begin bad++; $display("FAIL fixed_stuff_ok: got %b want 0", bus.stuff_err_o); end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        tick(1, (p == 0) ? 1'b0 : 1'($urandom_range(1)), 0, 1);
        total++;
        if (bus.bit_de_stuff_o !== (i == 3)) begin
          bad++; $display("FAIL fixed_period p%0d i%0d: got %b want %b", p, i, bus.bit_de_stuff_o, (i == 3));
        end
      end
      tick(1, ~m_prev, 0, 1);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL fixed_stuff p%0d: got %b want %b", p, obs_vec(), exp_vec()); end
    end
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1); tick(1, 1, 0, 1); tick(1, 0, 0, 1);
    tick(1, 1, 1, 1);
    tick(1, 1, 0, 1);
    total++;
    if (bus.stuff_err_o !== 1'b1) begin bad++; $display("FAIL fixed_stuff_err: got %b want 1", bus.stuff_err_o); end
    repeat (3) tick(1, 1, 0, 1);
    total++;
    if (bus.bit_de_stuff_o !== 1'b0) begin bad++; $display("FAIL fixed_no_dynamic: got %b want 0", bus.bit_de_stuff_o); end
    tick(1, 1, 0, 1);
    total++;
    if (bus.bit_de_stuff_o !== 1'b1) begin bad++; $display("FAIL fixed_after_run: got %b want 1", bus.bit_de_stuff_o); end
  endtask
`else
  task automatic test_fixed();
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1); tick(1, 1, 0, 1); tick(1, 0, 0, 1);
    tick(1, 1, 1, 1);
    total++;
    if (bus.bit_de_stuff_o !== 1'b0) begin bad++; $display("FAIL fixed_ignored: got %b want 0", bus.bit_de_stuff_o); end
    repeat (4) tick(1, 1, 0, 1);
    total++;
    if (bus.bit_de_stuff_o !== 1'b1) begin bad++; $display("FAIL dyn_after_ignored: got %b want 1", bus.bit_de_stuff_o); end
  endtask
`endif

  task automatic test_en_drop();
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1);
    repeat (4) tick(1, 0, 0, 1);
    tick(1, 1, 0, 1);
    repeat (4) tick(1, 1, 0, 1);
    total++;
    if (bus.bit_de_stuff_o !== 1'b1) begin bad++; $display("FAIL drop_pre_flag: got %b want 1", bus.bit_de_stuff_o); end
    tick(1, 1, 0, 0);
    total++;
    if ({bus.bit_de_stuff_o, bus.stuff_err_o, bus.stuff_cnt_o} !== 5'b00_001) begin
      bad++; $display("FAIL drop_on_sample: got %b want 00001", {bus.bit_de_stuff_o, bus.stuff_err_o, bus.stuff_cnt_o});
    end
    tick(1, 1, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL drop_idle: got %b want %b", obs_vec(), exp_vec()); end
  endtask

  task automatic test_reset_mid_frame();
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 1);
    repeat (4) tick(1, 0, 0, 1);
    tick(1, 1, 0, 1);
    tick(1, 0, 0, 1);
    tick(1, 1, 1, 1);
`ifdef CAN_DESTUFF_FIXED_EN
    total++;
    if (bus.bit_de_stuff_o !== 1'b1) begin bad++; $display("FAIL rst_pre_fixed: got %b want 1", bus.bit_de_stuff_o); end
`endif
    @(negedge clk);
    #2 rst = 1;
    #1;
    model_reset();
    total++;
    if (obs_vec() !== 7'd0) begin bad++; $display("FAIL rst_async: got %b want %b", obs_vec(), 7'd0); end
    @(negedge clk); rst = 0;
    tick(1, 0, 0, 1);
    repeat (3) tick(1, 0, 0, 1);
    total++;
    if (obs_vec() !== 7'd0) begin bad++; $display("FAIL rst_restart: got %b want 0000000", obs_vec()); end
    tick(1, 0, 0, 1);
    total++;
    if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rst_restart_flag: got %b want %b", obs_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    bit b, fs;
    for (int f = 0; f < 40; f++) begin
      int nbits = int'($urandom_range(60, 20));
      for (int n = 0; n < nbits; n++) begin
        int gap = int'($urandom_range(2));
        for (int g = 0; g < gap; g++) begin
          tick(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1);
          total++;
          if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rand_gap f%0d n%0d: got %b want %b", f, n, obs_vec(), exp_vec()); end
        end
        if (m_state == 0)  b = ($urandom_range(9) == 0);
        else if (m_flag)   b = ($urandom_range(9) == 0) ? m_prev : ~m_prev;
        else               b = ($urandom_range(9) < 7) ? m_prev : ~m_prev;
        fs = ($urandom_range(24) == 0);
        tick(1, b, fs, 1);
        total++;
        if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rand_bit f%0d n%0d: got %b want %b", f, n, obs_vec(), exp_vec()); end
      end
      tick(1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin bad++; $display("FAIL rand_eof f%0d: got %b want %b", f, obs_vec(), exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_dynamic_stuff();
    test_stuff_error();
    test_count_wrap();
    test_fixed();
    test_en_drop();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
